// File: rtl/exec_writeback_unit.sv
// +----------------------------------------------------------------------------+
// | exec_writeback_unit: execute stage feeding the register-file write port.   |
// | Optional feature macro: EXEC_OVERFLOW_EN (adds signed-overflow output).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module exec_writeback_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic [WIDTH-1:0]  wb_data,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_enable,
  output logic              zero,
  output logic              busy
`ifdef EXEC_OVERFLOW_EN
  ,
  output logic              overflow
`endif
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SLL   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;
  localparam int         CNT_W    = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  mdest_q, mdest_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   sum, diff, alu_res, acc_sum;
  logic               accept;

  assign sum     = operand_a + operand_b;
  assign diff    = operand_a - operand_b;
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = sum;
      OP_SUB:   alu_res = diff;
      OP_AND:   alu_res = operand_a & operand_b;
      OP_OR:    alu_res = operand_a | operand_b;
      OP_XOR:   alu_res = operand_a ^ operand_b;
      OP_SLL:   alu_res = operand_a << operand_b[4:0];
      OP_PASSB: alu_res = operand_b;
      default:  alu_res = '0;
    endcase
  end

`ifdef EXEC_OVERFLOW_EN
  logic ovf_q, ovf_d, ovf_res;

  always_comb begin
    ovf_res = 1'b0;
    if (op == OP_ADD)
      ovf_res = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (sum[WIDTH-1] != operand_a[WIDTH-1]);
    else if (op == OP_SUB)
      ovf_res = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (diff[WIDTH-1] != operand_a[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_WB);
  assign accept    = in_valid && in_ready;
  assign wb_enable = (state_q == S_WB);
  assign busy      = (state_q == S_MUL);
  assign wb_data   = data_q;
  assign wb_addr   = addr_q;
  assign zero      = zero_q;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    addr_d   = addr_q;
    mdest_d  = mdest_q;
    zero_d   = zero_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`ifdef EXEC_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_WB: begin
        if (accept && op == OP_MUL) begin
          mcand_d  = operand_a;
          mplier_d = operand_b;
          mdest_d  = dest_addr;
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH);
          state_d  = S_MUL;
        end else if (accept) begin
          data_d  = alu_res;
          addr_d  = dest_addr;
          zero_d  = (alu_res == '0);
`ifdef EXEC_OVERFLOW_EN
          ovf_d   = ovf_res;
`endif
          state_d = S_WB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        // Last iteration: the freshly summed accumulator is the product.
        if (cnt_q == CNT_W'(1)) begin
          data_d  = acc_sum;
          addr_d  = mdest_q;
          zero_d  = (acc_sum == '0);
`ifdef EXEC_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
          state_d = S_WB;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      addr_q   <= '0;
      mdest_q  <= '0;
      zero_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      mdest_q  <= mdest_d;
      zero_q   <= zero_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exec_writeback_unit.sv
// +----------------------------------------------------------------------------+
// | tb_exec_writeback_unit: self-checking bench for exec_writeback_unit.       |
// | Honours EXEC_OVERFLOW_EN when defined. Revision: 1.0                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_exec_writeback_unit;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 3;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, SLL = 3'b101, MUL = 3'b110, PASSB = 3'b111;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [WIDTH-1:0]  operand_a, operand_b;
  logic [ADDR_W-1:0] dest_addr;
  logic [WIDTH-1:0]  wb_data;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_enable, zero, busy;
`ifdef EXEC_OVERFLOW_EN
  logic              overflow;
`endif

  exec_writeback_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .dest_addr(dest_addr),
    .wb_data(wb_data), .wb_addr(wb_addr), .wb_enable(wb_enable),
    .zero(zero), .busy(busy)
`ifdef EXEC_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  dest;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec-level result: plain arithmetic, product truncated to 32 bits.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (o)
      ADD:   return a + b;
      SUB:   return a - b;
      AND_:  return a & b;
      OR_:   return a | b;
      XOR_:  return a ^ b;
      SLL:   return a << b[4:0];
      MUL:   begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      default: return b;
    endcase
  endfunction

  function automatic logic ovf_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == ADD)      r = sa + sb;
    else if (o == SUB) r = sa - sb;
    else               return 1'b0;
    return (r > longint'(32'h7FFFFFFF)) || (r < -longint'(32'h80000000));
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] d, input logic [31:0] exp, input string tag);
    int lat;
    int busyc;
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; operand_a = a; operand_b = b; dest_addr = d;
    tick();
    in_valid = 1'b0; operand_a = $urandom; operand_b = $urandom; dest_addr = 3'(~d);
    lat = 1;
    busyc = 0;
    while (!wb_enable && lat < 100) begin
      if (busy && !in_ready) busyc++;
      tick();
      lat++;
    end
    chk({tag, " wb_enable"}, {31'd0, wb_enable}, 32'd1);
    chk({tag, " latency"}, lat, (o == MUL) ? 32'd33 : 32'd1);
    chk({tag, " busy_cycles"}, busyc, (o == MUL) ? 32'd32 : 32'd0);
    chk({tag, " wb_data"}, wb_data, exp);
    chk({tag, " wb_addr"}, {29'd0, wb_addr}, {29'd0, d});
    chk({tag, " zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
    chk({tag, " busy_at_wb"}, {31'd0, busy}, 32'd0);
`ifdef EXEC_OVERFLOW_EN
    chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, ovf_model(o, a, b)});
`endif
    tick();
    chk({tag, " wb_enable_after"}, {31'd0, wb_enable}, 32'd0);
    chk({tag, " wb_data_hold"}, wb_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro, rd;
    logic [31:0] ra, rb;
    int          seen;

    tbl[0]  = '{ADD,   32'hACEDCAFE, 32'h00000001, 3'd0, 32'hACEDCAFF};
    tbl[1]  = '{SUB,   32'hDEADBEEF, 32'hDEADBEEF, 3'd3, 32'h00000000};
    tbl[2]  = '{MUL,   32'h0000FFFF, 32'h00010001, 3'd7, 32'hFFFFFFFF};
    tbl[3]  = '{XOR_,  32'hFFFFFFFF, 32'h0F0F0F0F, 3'd1, 32'hF0F0F0F0};
    tbl[4]  = '{SLL,   32'h00000001, 32'h00000024, 3'd2, 32'h00000010};
    tbl[5]  = '{AND_,  32'hF0F0F0F0, 32'h0FF00FF0, 3'd4, 32'h00F000F0};
    tbl[6]  = '{OR_,   32'h00000F00, 32'h000000F0, 3'd5, 32'h00000FF0};
    tbl[7]  = '{PASSB, 32'hFFFFFFFF, 32'h12345678, 3'd6, 32'h12345678};
    tbl[8]  = '{SUB,   32'h00000000, 32'h00000001, 3'd2, 32'hFFFFFFFF};
    tbl[9]  = '{ADD,   32'hFFFFFFFF, 32'h00000001, 3'd1, 32'h00000000};
    tbl[10] = '{SLL,   32'h80000001, 32'hFFFFFFFF, 3'd3, 32'h80000000};
    tbl[11] = '{MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 3'd5, 32'h00000001};
    tbl[12] = '{MUL,   32'h12345678, 32'h00000000, 3'd0, 32'h00000000};

    rst = 1'b1; in_valid = 1'b0; op = '0; operand_a = '0; operand_b = '0; dest_addr = '0;
    tick();
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset wb_addr", {29'd0, wb_addr}, 32'd0);
    chk("reset wb_enable", {31'd0, wb_enable}, 32'd0);
    chk("reset zero", {31'd0, zero}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
`ifdef EXEC_OVERFLOW_EN
    chk("reset overflow", {31'd0, overflow}, 32'd0);
`endif
    rst = 1'b0;
    tick();
    chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 13; i++)
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dest, tbl[i].exp, $sformatf("vec%0d", i));

    // Zero flag persists across idle cycles.
    do_op(SUB, 32'hDEADBEEF, 32'hDEADBEEF, 3'd3, 32'd0, "sub_zero");
    repeat (3) tick();
    chk("zero hold idle", {31'd0, zero}, 32'd1);
    chk("wb_enable idle", {31'd0, wb_enable}, 32'd0);

    // Back-to-back: new requests presented while the previous result is in WB.
    in_valid = 1'b1; op = ADD; operand_a = 32'd5; operand_b = 32'd6; dest_addr = 3'd1;
    tick();
    op = XOR_; operand_a = 32'hFFFFFFFF; operand_b = 32'h0F0F0F0F; dest_addr = 3'd2;
    chk("b2b add wb_enable", {31'd0, wb_enable}, 32'd1);
    chk("b2b add in_ready", {31'd0, in_ready}, 32'd1);
    chk("b2b add data", wb_data, 32'd11);
    tick();
    op = SLL; operand_a = 32'h1; operand_b = 32'h24; dest_addr = 3'd4;
    chk("b2b xor wb_enable", {31'd0, wb_enable}, 32'd1);
    chk("b2b xor data", wb_data, 32'hF0F0F0F0);
    chk("b2b xor addr", {29'd0, wb_addr}, 32'd2);
    tick();
    in_valid = 1'b0;
    chk("b2b sll wb_enable", {31'd0, wb_enable}, 32'd1);
    chk("b2b sll data", wb_data, 32'h00000010);
    tick();
    chk("b2b end wb_enable", {31'd0, wb_enable}, 32'd0);

    // Reset during a multiply discards it.
    do_op(ADD, 32'h11110000, 32'h00002222, 3'd6, 32'h11112222, "pre_abort");
    in_valid = 1'b1; op = MUL; operand_a = 32'h00000003; operand_b = 32'h00000005; dest_addr = 3'd5;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("mid-mul busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort wb_data", wb_data, 32'd0);
    chk("abort wb_addr", {29'd0, wb_addr}, 32'd0);
    chk("abort wb_enable", {31'd0, wb_enable}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort zero", {31'd0, zero}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("abort in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (wb_enable) seen++;
      tick();
    end
    chk("abort no wb pulse", seen, 32'd0);
    do_op(ADD, 32'h00000010, 32'h00000020, 3'd2, 32'h00000030, "post_abort");

`ifdef EXEC_OVERFLOW_EN
    do_op(ADD, 32'h7FFFFFFF, 32'h00000001, 3'd1, 32'h80000000, "ovf_add");
    chk("ovf_add held", {31'd0, overflow}, 32'd1);
    do_op(SUB, 32'h80000000, 32'h00000001, 3'd2, 32'h7FFFFFFF, "ovf_sub");
    chk("ovf_sub held", {31'd0, overflow}, 32'd1);
    do_op(AND_, 32'hFFFFFFFF, 32'h80000000, 3'd3, 32'h80000000, "ovf_and");
    chk("ovf_and held", {31'd0, overflow}, 32'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? ra : $urandom;
      rd = 3'($urandom_range(0, 7));
      do_op(ro, ra, rb, rd, model(ro, ra, rb), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exec_writeback_unit.md
Name: exec_writeback_unit

Overview:
- Execute stage directly downstream of the 8x32 register file.
- Consumes the two read-port operands plus an opcode and destination address, computes a result, and produces the register file's write-side signals (data, address, write enable).
- Most operations take one cycle; MUL is an iterative shift-add multiply.
- A valid/ready handshake lets the sequencer stall while a multiply is in progress.

Parameters:
- WIDTH, 32, operand/result width (matches register width).
- ADDR_W, 3, destination register address width (8 registers).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept a request this cycle
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 MUL, 111 PASSB
- operand_a  input  WIDTH  from register file read port 1
- operand_b  input  WIDTH  from register file read port 2
- dest_addr  input  ADDR_W  destination register
- wb_data  output  WIDTH  write data to register file
- wb_addr  output  ADDR_W  write address to register file
- wb_enable  output  1  one-cycle write strobe to register file
- zero  output  1  last written-back result was zero
- busy  output  1  multiply in progress

Behaviour:
- Reset (asynchronous, immediate) clears all outputs:
  - wb_data=0, wb_addr=0, wb_enable=0, zero=0, busy=0.
  - State returns to IDLE. in_ready=1 once reset is released.
- States:
  - IDLE: no result pending.
  - MUL: iterating.
  - WB: wb_enable=1 for exactly this cycle.
- in_ready = (state==IDLE) || (state==WB). A transfer occurs on a rising edge with in_valid && in_ready. Inputs are sampled only on a transfer.
- Non-MUL transfer in cycle N:
  - Result, dest_addr and zero are registered; state goes to WB.
  - wb_enable is high in cycle N+1 with wb_data/wb_addr valid.
- MUL transfer in cycle N:
  - Operands are latched, the accumulator is cleared, the counter is loaded with WIDTH, busy=1, and state goes to MUL.
  - Each MUL cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator; shift the multiplicand left 1 and the multiplier right 1; decrement the counter.
  - When the counter reaches 0, go to WB. wb_enable is high in cycle N+WIDTH+1 and busy drops in that same cycle.
  - The result is the low WIDTH bits of the product.
- WB with no new transfer goes to IDLE. WB with a transfer behaves as IDLE with a transfer, giving back-to-back single-cycle throughput.
- wb_data, wb_addr and zero hold their values after WB until the next WB. wb_enable is 0 outside WB.
- Arithmetic is modulo 2^WIDTH; carries are discarded.
- SUB = a - b (two's complement).
- SLL shifts by operand_b[4:0] only; upper bits of b are ignored.
- PASSB returns operand_b.
- dest_addr 0 is an ordinary register; there is no hardwired zero.
- in_valid during MUL is ignored (in_ready=0). The requester must hold it.
- Reset during MUL aborts the operation: no wb_enable pulse is produced and the partial product is discarded.
- zero = (result==0), updated only when entering WB.

Optional Feature:
- Macro: EXEC_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit), registered alongside wb_data.
  - overflow=1 on ADD when both operands have the same sign and the result sign differs.
  - overflow=1 on SUB when the operands' signs differ and the result sign differs from a's.
  - overflow=0 for all other ops.
  - Reset value is 0.
- Undefined: the port and its logic are absent.

Test Plan:
- ADD a=0xACEDCAFE, b=0x00000001, dest=000, transfer cycle N -> cycle N+1: wb_enable=1, wb_data=0xACEDCAFF, wb_addr=000, zero=0; cycle N+2: wb_enable=0.
- SUB a=b=0xDEADBEEF, dest=011 -> wb_data=0x00000000, zero=1, wb_addr=011; zero stays 1 through idle cycles.
- MUL a=0x0000FFFF, b=0x00010001, dest=111, transfer N -> in_ready=0 and busy=1 in cycles N+1..N+32; cycle N+33: wb_enable=1, wb_data=0xFFFFFFFF, busy=0.
- Back-to-back: ADD then XOR a=0xFFFFFFFF, b=0x0F0F0F0F presented while in WB -> consecutive wb_enable pulses, second wb_data=0xF0F0F0F0; SLL a=0x1, b=0x24 -> 0x00000010.
- Reset asserted mid-MUL (cycle N+10) -> all outputs 0 immediately, no wb_enable pulse ever appears; after release in_ready=1 and a new ADD completes normally.
- EXEC_OVERFLOW_EN defined: ADD 0x7FFFFFFF+0x00000001 -> wb_data=0x80000000, overflow=1; SUB 0x80000000-0x00000001 -> overflow=1; AND -> overflow=0.
